// File: rtl/tdc_read_sched_pkg.sv
// ============================================================================
// tdc_read_sched_pkg : shared TDC widths and read-scheduler state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package tdc_read_sched_pkg;

    localparam int TDC_DATA_W = 28;
    localparam int TDC_ADDR_W = 4;
    localparam int TMO_CNT_W  = 10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } tdc_state_t;

endpackage

`default_nettype wire

// File: rtl/tdc_read_sched_rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin picker, first set req at/after rr_ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic             valid,
    output logic [PTR_W-1:0] winner
);

    int               idx;
    logic [PTR_W-1:0] idx_p;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_p  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            idx_p = PTR_W'(idx);
            if (!valid && req[idx_p]) begin
                valid  = 1'b1;
                winner = idx_p;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tdc_read_sched.sv
// ============================================================================
// tdc_read_sched : round-robin scheduler of TDC register reads with timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module tdc_read_sched
    import tdc_read_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int READ_CYC = 2,
    parameter int TMO_CYC  = 1023
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [TDC_ADDR_W*N_REQ-1:0] req_addr,
    output logic [N_REQ-1:0]            done,
    output logic                        tmo,
    output logic [TDC_DATA_W-1:0]       rsp_data,
    output logic                        busy,
    output logic                        read,
    output logic [TDC_ADDR_W-1:0]       addr_in,
    input  logic [TDC_DATA_W-1:0]       data_out,
    input  logic                        alu_trigger
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [TMO_CNT_W-1:0] ISSUE_LAST = TMO_CNT_W'(READ_CYC - 1);
    // Timeout fires on the WAIT cycle in which the counter steps up to TMO_CYC.
    localparam logic [TMO_CNT_W-1:0] TMO_LAST   = TMO_CNT_W'(TMO_CYC - 1);

    tdc_state_t           state, state_next;
    logic [PTR_W-1:0]     rr_ptr, winner, pick_idx;
    logic                 pick_valid;
    logic [TMO_CNT_W-1:0] cnt;
    logic                 tmo_flag;
    logic                 grant_en, capture_en, timeout_en, cnt_clr;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .winner (pick_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        capture_en = 1'b0;
        timeout_en = 1'b0;
        cnt_clr    = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_en   = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cnt == ISSUE_LAST) begin
                    cnt_clr    = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (alu_trigger) begin
                    capture_en = 1'b1;
                    state_next = S_RESP;
                end else if (cnt == TMO_LAST) begin
                    timeout_en = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                cnt_clr    = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr   <= '0;
            winner   <= '0;
            addr_in  <= '0;
            cnt      <= '0;
            tmo_flag <= 1'b0;
            rsp_data <= '0;
        end else begin
            if (grant_en) begin
                winner  <= pick_idx;
                addr_in <= req_addr[{pick_idx, 2'b00} +: TDC_ADDR_W];
                rr_ptr  <= (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (state == S_ISSUE || state == S_WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (capture_en) begin
                rsp_data <= data_out;
                tmo_flag <= 1'b0;
            end else if (timeout_en) begin
                tmo_flag <= 1'b1;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign read = (state == S_ISSUE);
    assign done = (state == S_RESP) ? (N_REQ'(1) << winner) : '0;
    assign tmo  = (state == S_RESP) & tmo_flag;

endmodule

`default_nettype wire

// File: tb/tb_tdc_read_sched.sv
// ============================================================================
// tb_tdc_read_sched : directed self-checking bench for tdc_read_sched
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tdc_read_sched;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [15:0] req_addr;
    logic [3:0]  done;
    logic        tmo;
    logic [27:0] rsp_data;
    logic        busy;
    logic        read;
    logic [3:0]  addr_in;
    logic [27:0] data_out;
    logic        alu_trigger;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tdc_read_sched #(
        .N_REQ    (4),
        .READ_CYC (2),
        .TMO_CYC  (1023)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_addr    (req_addr),
        .done        (done),
        .tmo         (tmo),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .read        (read),
        .addr_in     (addr_in),
        .data_out    (data_out),
        .alu_trigger (alu_trigger)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Grant from IDLE, trigger in the first WAIT cycle, end back in IDLE.
    task automatic do_txn(input int w, input logic [3:0] a, input logic [27:0] d);
        tick();
        chk("grant_read", 32'(read), 32'd1);
        chk("grant_addr", 32'(addr_in), 32'(a));
        chk("grant_busy", 32'(busy), 32'd1);
        tick();
        chk("issue2_read", 32'(read), 32'd1);
        tick();
        chk("wait_read", 32'(read), 32'd0);
        chk("wait_done", 32'(done), 32'd0);
        alu_trigger = 1'b1;
        data_out    = d;
        tick();
        chk("resp_done", 32'(done), 32'(1) << w);
        chk("resp_tmo", 32'(tmo), 32'd0);
        chk("resp_data", 32'(rsp_data), 32'(d));
        chk("resp_addr", 32'(addr_in), 32'(a));
        alu_trigger = 1'b0;
        data_out    = '0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        reset_n     = 1'b0;
        req         = '0;
        req_addr    = '0;
        data_out    = '0;
        alu_trigger = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tmo", 32'(tmo), 32'd0);
        chk("rst_rsp", 32'(rsp_data), 32'd0);
        chk("rst_addr", 32'(addr_in), 32'd0);
        reset_n = 1'b1;
        tick();

        // Fairness: all requesting, grants 0,1,2,3,0 with one IDLE between
        req      = 4'b1111;
        req_addr = 16'hBA98;
        do_txn(0, 4'h8, 28'd100);
        do_txn(1, 4'h9, 28'd101);
        do_txn(2, 4'hA, 28'd102);
        do_txn(3, 4'hB, 28'd103);
        do_txn(0, 4'h8, 28'd104);
        req = '0;

        // Single request, trigger 3 cycles after read falls, req dropped mid-flight
        req      = 4'b0001;
        req_addr = 16'h0005;
        tick();
        chk("single_read1", 32'(read), 32'd1);
        chk("single_addr", 32'(addr_in), 32'h5);
        tick();
        chk("single_read2", 32'(read), 32'd1);
        tick();
        chk("single_readfall", 32'(read), 32'd0);
        req = '0;
        tick();
        tick();
        tick();
        chk("single_w3_done", 32'(done), 32'd0);
        chk("single_w3_busy", 32'(busy), 32'd1);
        alu_trigger = 1'b1;
        data_out    = 28'd1234;
        tick();
        chk("single_done", 32'(done), 32'b0001);
        chk("single_tmo", 32'(tmo), 32'd0);
        chk("single_data", 32'(rsp_data), 32'd1234);
        alu_trigger = 1'b0;
        data_out    = '0;
        tick();
        chk("single_idle_busy", 32'(busy), 32'd0);
        chk("single_idle_done", 32'(done), 32'd0);

        // Spurious strobe in IDLE
        alu_trigger = 1'b1;
        data_out    = 28'hFFFFFFF;
        tick();
        chk("spur_done", 32'(done), 32'd0);
        chk("spur_busy", 32'(busy), 32'd0);
        chk("spur_rsp", 32'(rsp_data), 32'd1234);
        alu_trigger = 1'b0;
        data_out    = '0;
        tick();
        chk("spur_busy2", 32'(busy), 32'd0);
        chk("spur_rsp2", 32'(rsp_data), 32'd1234);

        // Timeout on requester 2
        req      = 4'b0100;
        req_addr = 16'h0300;
        tick();
        chk("tmo_addr", 32'(addr_in), 32'h3);
        tick();
        tick();
        chk("tmo_readfall", 32'(read), 32'd0);
        n = 0;
        while (done == 4'b0000 && n < 2000) begin
            tick();
            n++;
        end
        chk("tmo_latency", 32'(n), 32'd1023);
        chk("tmo_done", 32'(done), 32'b0100);
        chk("tmo_flag", 32'(tmo), 32'd1);
        chk("tmo_rsp", 32'(rsp_data), 32'd1234);
        req = '0;
        tick();
        chk("tmo_after_tmo", 32'(tmo), 32'd0);
        chk("tmo_after_done", 32'(done), 32'd0);

        // Trigger coincides with counter reaching the limit
        req = 4'b0100;
        tick();
        tick();
        tick();
        chk("coin_readfall", 32'(read), 32'd0);
        repeat (1022) tick();
        chk("coin_pre_done", 32'(done), 32'd0);
        chk("coin_pre_busy", 32'(busy), 32'd1);
        alu_trigger = 1'b1;
        data_out    = 28'hABCDEF1;
        tick();
        chk("coin_done", 32'(done), 32'b0100);
        chk("coin_tmo", 32'(tmo), 32'd0);
        chk("coin_data", 32'(rsp_data), 32'hABCDEF1);
        alu_trigger = 1'b0;
        data_out    = '0;
        req         = '0;
        tick();

        // Reset asserted mid-WAIT
        req      = 4'b0001;
        req_addr = 16'h0007;
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("mid_busy_pre", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_read", 32'(read), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_tmo", 32'(tmo), 32'd0);
        chk("mid_rsp", 32'(rsp_data), 32'd0);
        chk("mid_addr", 32'(addr_in), 32'd0);
        req = '0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        tick();
        chk("post_rst_done2", 32'(done), 32'd0);
        req      = 4'b0010;
        req_addr = 16'h00A0;
        do_txn(1, 4'hA, 28'h0555AAA);
        req = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
